// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // Width of the iteration counter for a given operand width.
  function automatic int iter_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract divisor, keep or restore.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic        [WIDTH:0] shifted;
  logic signed [WIDTH:0] trial;

  // rem < divisor always holds, so the shifted value is below 2*divisor and the
  // WIDTH+1-bit difference cannot wrap; its MSB is a clean sign.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = signed'(shifted) - signed'({1'b0, divisor});

  always_comb begin
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider32.sv
// Multi-cycle restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define DIV_SIGNED_EN to build two's-complement support selected by op_signed.
module seq_divider32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             op_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int         ITER_W  = iter_w(WIDTH);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]        state;
  logic [ITER_W-1:0] count;
  logic [WIDTH-1:0]  rem_r;
  logic [WIDTH-1:0]  quo_r;
  logic [WIDTH-1:0]  divisor_r;
  logic [WIDTH-1:0]  rem_next;
  logic [WIDTH-1:0]  quo_next;
  logic [WIDTH-1:0]  dvd_mag;
  logic [WIDTH-1:0]  dvs_mag;
  logic [WIDTH-1:0]  q_final;
  logic [WIDTH-1:0]  r_final;
  logic              accept;

  assign accept    = (state == ST_IDLE) && in_valid && in_ready;
  assign out_valid = (state == ST_DONE);

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  assign dvd_mag = apply_sign(dividend, op_signed && dividend[WIDTH-1]);
  assign dvs_mag = apply_sign(divisor,  op_signed && divisor[WIDTH-1]);
  assign q_final = apply_sign(quo_next, neg_q);
  assign r_final = apply_sign(rem_next, neg_r);

  // Sign bits captured at accept; MIN/-1 falls out of the magnitude path unchanged.
  always_ff @(posedge clk) begin
    if (accept) begin
      neg_q <= op_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r <= op_signed && dividend[WIDTH-1];
    end
  end
`else
  logic unused_op_signed;

  assign unused_op_signed = op_signed;
  assign dvd_mag          = dividend;
  assign dvs_mag          = divisor;
  assign q_final          = quo_next;
  assign r_final          = rem_next;
`endif

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem_r),
    .quo     (quo_r),
    .divisor (divisor_r),
    .rem_next(rem_next),
    .quo_next(quo_next)
  );

  // Working registers: datapath only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_r     <= '0;
      quo_r     <= dvd_mag;
      divisor_r <= dvs_mag;
    end else if (state == ST_BUSY) begin
      rem_r <= rem_next;
      quo_r <= quo_next;
    end
  end

  // Control FSM and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      count       <= '0;
      in_ready    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state       <= ST_DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state       <= ST_BUSY;
              count       <= ITER_W'(WIDTH - 1);
              div_by_zero <= 1'b0;
            end
          end
        end
        ST_BUSY: begin
          if (count == '0) begin
            state     <= ST_DONE;
            quotient  <= q_final;
            remainder <= r_final;
          end else begin
            count <= count - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state    <= ST_IDLE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider32.sv
// Directed bench for seq_divider32: values, latency, divide-by-zero, back-pressure, mid-op reset.
module tb_seq_divider32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        op_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  seq_divider32 #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .op_signed  (op_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) chk(tag, {31'b0, in_ready}, 32'd1);
  endtask

  // Presents one operation, returns the number of edges after the accepting edge
  // until out_valid is seen (0 means visible right after the accepting edge).
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output int latency);
    wait_ready("in_ready_wait");
    dividend  = a;
    divisor   = b;
    op_signed = sgn;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    latency  = 0;
    while (!out_valid && latency < 100) begin
      @(posedge clk); #1;
      latency++;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] q, input logic [31:0] r,
                              input logic dz);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_q"}, quotient, q);
    chk({tag, "_r"}, remainder, r);
    chk({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, dz});
  endtask

  task automatic check_popped(input string tag);
    @(posedge clk); #1;
    chk({tag, "_pop_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_pop_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    op_signed = 1'b0;
    out_ready = 1'b1;
    #23;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    run_div(32'd100, 32'd7, 1'b0, lat);
    chk("100_7_lat", lat, 32'd32);
    check_result("100_7", 32'd14, 32'd2, 1'b0);
    check_popped("100_7");

    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, lat);
    check_result("max_1", 32'hFFFF_FFFF, 32'd0, 1'b0);
    check_popped("max_1");

    run_div(32'd5, 32'd9, 1'b0, lat);
    check_result("5_9", 32'd0, 32'd5, 1'b0);
    check_popped("5_9");

    run_div(32'h1234, 32'd0, 1'b0, lat);
    chk("dz_lat", lat, 32'd0);
    check_result("dz", 32'hFFFF_FFFF, 32'h1234, 1'b1);
    check_popped("dz");

    // Back-pressure: result held, new requests ignored.
    out_ready = 1'b0;
    run_div(32'd1000, 32'd33, 1'b0, lat);
    chk("bp_lat", lat, 32'd32);
    check_result("bp", 32'd30, 32'd10, 1'b0);
    for (int i = 0; i < 10; i++) begin
      dividend = 32'd7;
      divisor  = 32'd1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_q", quotient, 32'd30);
      chk("bp_hold_r", remainder, 32'd10);
      chk("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_popped("bp");
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("bp_no_extra", {31'b0, seen}, 32'd0);

`ifdef DIV_SIGNED_EN
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, lat);
    chk("s_m7_2_lat", lat, 32'd32);
    check_result("s_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    check_popped("s_m7_2");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, lat);
    check_result("s_7_m2", 32'hFFFF_FFFD, 32'd1, 1'b0);
    check_popped("s_7_m2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
    check_result("s_min_m1", 32'h8000_0000, 32'd0, 1'b0);
    check_popped("s_min_m1");
`else
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, lat);
    check_result("u_sgn_ign", 32'h7FFF_FFFC, 32'd1, 1'b0);
    check_popped("u_sgn_ign");
`endif

    // Reset during iteration 15.
    wait_ready("rst_mid_wait");
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
    end
    chk("busy_in_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("mid_rst_q", quotient, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", {31'b0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("rel_no_result", {31'b0, seen}, 32'd0);

    run_div(32'd81, 32'd9, 1'b0, lat);
    chk("81_9_lat", lat, 32'd32);
    check_result("81_9", 32'd9, 32'd0, 1'b0);
    check_popped("81_9");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
